// File: rtl/uart_tx_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_core                                                 |
// | Description : 8N1 UART transmitter (LSB first). It accepts one byte per     |
// |               tx_req while idle and reports occupancy on tx_busy.           |
// |               The optional macro UART_TX_PARITY_EN inserts a parity bit.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 234
`ifdef UART_TX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_tx
);

  localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  localparam int c_ST_W = 3;
`else
  localparam int c_ST_W = 2;
`endif
  localparam logic [c_ST_W-1:0] c_ST_IDLE   = c_ST_W'(0);
  localparam logic [c_ST_W-1:0] c_ST_START  = c_ST_W'(1);
  localparam logic [c_ST_W-1:0] c_ST_DATA   = c_ST_W'(2);
  localparam logic [c_ST_W-1:0] c_ST_STOP   = c_ST_W'(3);
`ifdef UART_TX_PARITY_EN
  localparam logic [c_ST_W-1:0] c_ST_PARITY = c_ST_W'(4);
`endif

  logic [c_ST_W-1:0]  r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;

  logic [c_ST_W-1:0]  w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [2:0]         w_idx_nxt;
  logic [7:0]         w_shift_nxt;
  logic               w_bit_end;
  logic               w_tx_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  assign w_bit_end = (r_cnt == c_CNT_MAX);

  // State register; outputs are registered alongside so the pin never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      uart_tx <= w_tx_nxt;
      tx_busy <= w_busy_nxt;
      tx_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    if (r_state != c_ST_IDLE) begin
      w_cnt_nxt = w_bit_end ? '0 : r_cnt + c_CNT_W'(1);
    end
    case (r_state)
      c_ST_IDLE: begin
        if (tx_req) begin
          w_state_nxt = c_ST_START;
          w_shift_nxt = tx_data;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      c_ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = c_ST_DATA;
          w_idx_nxt   = '0;
        end
      end
      c_ST_DATA: begin
        if (w_bit_end) begin
          if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = c_ST_PARITY;
`else
            w_state_nxt = c_ST_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      c_ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = c_ST_STOP;
        end
      end
`endif
      c_ST_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they align with the state edge.
  always_comb begin
    w_busy_nxt = (w_state_nxt != c_ST_IDLE);
    w_done_nxt = (r_state == c_ST_STOP) && (w_state_nxt == c_ST_IDLE);
    case (w_state_nxt)
      c_ST_START:  w_tx_nxt = 1'b0;
      c_ST_DATA:   w_tx_nxt = w_shift_nxt[w_idx_nxt];
`ifdef UART_TX_PARITY_EN
      c_ST_PARITY: w_tx_nxt = (^r_shift) ^ PARITY_ODD;
`endif
      default:     w_tx_nxt = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// Bench for uart_tx_core (8N1 build, CLKS_PER_BIT=4): directed stimulus pushes
// expected frames into a queue, an independent line monitor decodes and checks them.
module tb_uart_tx_core;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       uart_tx;

  always #5 clk = ~clk;

  uart_tx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_req  (tx_req),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .uart_tx (uart_tx)
  );

  typedef struct {
    logic [7:0] data;
    int         gap;   // required idle-high samples before start, -1 = any
  } exp_t;

  exp_t exp_q[$];
  int   n_checks       = 0;
  int   n_fails        = 0;
  int   frames_seen    = 0;
  int   frames_aborted = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] d);
    tx_req  = 1'b1;
    tx_data = d;
    push_exp(d, -1);
    @(posedge clk);
    #1;
    check("accept_busy", tx_busy, 1);
    check("accept_start_bit", uart_tx, 0);
    @(negedge clk);
    tx_req  = 1'b0;
    tx_data = 8'($urandom);
  endtask

  // Line monitor
  initial begin : monitor
    int         idle_cnt;
    bit         done_chk;
    bit         aborted;
    exp_t       e;
    logic [7:0] rx;
    int         bad_line, bad_busy, bad_done, ph;
    logic       exp_bit;
    idle_cnt = 1000;
    done_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        idle_cnt = 1000;
        done_chk = 1'b0;
        continue;
      end
      if (done_chk) begin
        check("done_one_cycle", tx_done, 0);
        done_chk = 1'b0;
      end
      if (uart_tx === 1'b0) begin
        check("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
        end else begin
          e.data = 8'h00;
          e.gap  = -1;
        end
        if (e.gap >= 0) check("idle_gap", idle_cnt, e.gap);
        bad_line = 0; bad_busy = 0; bad_done = 0; rx = 8'h00; aborted = 1'b0;
        for (int s = 0; s < 10 * CPB; s++) begin
          if (s > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          ph = s / CPB;
          exp_bit = (ph == 0) ? 1'b0 : (ph == 9) ? 1'b1 : e.data[ph-1];
          if (uart_tx !== exp_bit) bad_line++;
          if (ph >= 1 && ph <= 8 && (s % CPB) == CPB / 2) rx[ph-1] = uart_tx;
          if (tx_busy !== 1'b1) bad_busy++;
          if (tx_done !== 1'b0) bad_done++;
        end
        if (aborted) begin
          frames_aborted++;
          idle_cnt = 1000;
        end else begin
          frames_seen++;
          check("rx_byte", rx, e.data);
          check("line_shape", bad_line, 0);
          check("busy_in_frame", bad_busy, 0);
          check("no_early_done", bad_done, 0);
          @(negedge clk);
          check("busy_fall_at_10_bits", tx_busy, 0);
          check("done_pulse", tx_done, 1);
          check("idle_high_after_stop", uart_tx, 1);
          idle_cnt = 1;
          done_chk = 1'b1;
        end
      end else begin
        idle_cnt++;
      end
    end
  end

  initial begin : stimulus
    int bad;
    rst_n   = 1'b0;
    tx_req  = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_uart_tx", uart_tx, 1);
    check("reset_tx_busy", tx_busy, 0);
    check("reset_tx_done", tx_done, 0);
    rst_n = 1'b1;

    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check("idle_after_reset", bad, 0);

    // Single byte
    send(8'hA5);
    repeat (45) @(negedge clk);

    // Request while busy is dropped
    send(8'h55);
    repeat (10) @(negedge clk);
    tx_req  = 1'b1;
    tx_data = 8'hFF;
    @(posedge clk);
    #1;
    check("busy_ignores_req", tx_busy, 1);
    @(negedge clk);
    tx_req = 1'b0;
    repeat (45) @(negedge clk);

    // Back-to-back with tx_req held
    tx_req  = 1'b1;
    tx_data = 8'h00;
    push_exp(8'h00, -1);
    @(posedge clk);
    #1;
    check("b2b_first_accept", tx_busy, 1);
    @(negedge clk);
    tx_data = 8'hFF;
    push_exp(8'hFF, 1);
    repeat (40) @(posedge clk);
    #1;
    check("b2b_busy_gap", tx_busy, 0);
    @(posedge clk);
    #1;
    check("b2b_reaccept", tx_busy, 1);
    @(negedge clk);
    tx_req = 1'b0;
    repeat (45) @(negedge clk);

    // Reset during data bit 3 of 0x0F
    send(8'h0F);
    repeat (17) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_uart_tx", uart_tx, 1);
    check("midreset_tx_busy", tx_busy, 0);
    check("midreset_tx_done", tx_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h3C);
    repeat (45) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    check("frames_completed", frames_seen, 5);
    check("frames_aborted", frames_aborted, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
